// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus widths, handshake FSM states
// and the byte-strobe merge used by the register bank.
package axil_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    function automatic logic [AXIL_DATA_W-1:0] apply_strb(
        input logic [AXIL_DATA_W-1:0] old_val,
        input logic [AXIL_DATA_W-1:0] new_val,
        input logic [AXIL_STRB_W-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] res;
        res = old_val;
        for (int k = 0; k < AXIL_STRB_W; k++) begin
            if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_regbank.sv
// Register storage for the AXI4-Lite slave: byte-strobe writes, combinational
// read mux by index, and a flat export of every register.
module axil_regbank
    import axil_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_we,
    input  logic [IDX_W-1:0]              i_widx,
    input  logic [AXIL_DATA_W-1:0]        i_wdata,
    input  logic [AXIL_STRB_W-1:0]        i_wstrb,
    input  logic [IDX_W-1:0]              i_ridx,
    output logic [AXIL_DATA_W-1:0]        o_rdata,
    output logic [NUM_REGS*AXIL_DATA_W-1:0] o_regs
);

    logic [AXIL_DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_widx == IDX_W'(i)) r_regs[i] <= apply_strb(r_regs[i], i_wdata, i_wstrb);
            end
        end
    end

    // Loop mux rather than array indexing so a non-power-of-two bank never reads out of bounds.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_ridx == IDX_W'(i)) o_rdata = r_regs[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs[AXIL_DATA_W*g +: AXIL_DATA_W] = r_regs[g];
    end

endmodule

// File: rtl/axis_lite_s.sv
// AXI4-Lite slave: independent write/read handshake FSMs and address decode in
// front of an axil_regbank; register contents are exported on reg_out.
module axis_lite_s
    import axil_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_W-1:0]       s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXIL_DATA_W-1:0]  s_axi_wdata,
    input  logic [AXIL_STRB_W-1:0]  s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_W-1:0]       s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXIL_DATA_W-1:0]  s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [NUM_REGS*AXIL_DATA_W-1:0] reg_out
);

    localparam int                IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >= BASE) && (((addr - BASE) >> 2) < ADDR_W'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE) >> 2);
    endfunction

    wr_state_t              r_wstate;
    rd_state_t              r_rstate;
    logic                   r_awready;
    logic                   r_wready;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic [ADDR_W-1:0]      r_awaddr;
    logic [AXIL_DATA_W-1:0] r_wdata;
    logic [AXIL_STRB_W-1:0] r_wstrb;
    logic                   r_arready;
    logic                   r_rvalid;
    logic [1:0]             r_rresp;
    logic [AXIL_DATA_W-1:0] r_rdata;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_commit;
    logic [ADDR_W-1:0]      w_waddr;
    logic [AXIL_DATA_W-1:0] w_wdata_sel;
    logic [AXIL_STRB_W-1:0] w_wstrb_sel;
    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic [AXIL_DATA_W-1:0] w_rd_data;
    logic                   w_unused;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot};

    assign w_aw_hs = s_axi_awvalid & r_awready;
    assign w_w_hs  = s_axi_wvalid  & r_wready;
    assign w_ar_hs = s_axi_arvalid & r_arready;

    // The commit uses whichever half arrived earlier from its capture register.
    assign w_commit    = ((r_wstate == W_IDLE)    && w_aw_hs && w_w_hs) ||
                         ((r_wstate == W_HAVE_AW) && w_w_hs) ||
                         ((r_wstate == W_HAVE_W)  && w_aw_hs);
    assign w_waddr     = (r_wstate == W_HAVE_AW) ? r_awaddr : s_axi_awaddr;
    assign w_wdata_sel = (r_wstate == W_HAVE_W)  ? r_wdata  : s_axi_wdata;
    assign w_wstrb_sel = (r_wstate == W_HAVE_W)  ? r_wstrb  : s_axi_wstrb;
    assign w_wr_ok     = in_range(w_waddr);
    assign w_rd_ok     = in_range(s_axi_araddr);

    axil_regbank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regbank (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_we    (w_commit & w_wr_ok),
        .i_widx  (to_index(w_waddr)),
        .i_wdata (w_wdata_sel),
        .i_wstrb (w_wstrb_sel),
        .i_ridx  (to_index(s_axi_araddr)),
        .o_rdata (w_rd_data),
        .o_regs  (reg_out)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_wstate  <= W_RESP;
                    end else if (w_aw_hs) begin
                        r_awaddr  <= s_axi_awaddr;
                        r_awready <= 1'b0;
                        r_wstate  <= W_HAVE_AW;
                    end else if (w_w_hs) begin
                        r_wdata   <= s_axi_wdata;
                        r_wstrb   <= s_axi_wstrb;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_HAVE_W;
                    end else begin
                        // Also raises the readies on the first edge after reset.
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (w_w_hs) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_wstate <= W_RESP;
                    end
                end
                W_HAVE_W: begin
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_wstate  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata   <= w_rd_ok ? w_rd_data : '0;
                        r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_RESP;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;

endmodule

// File: doc/axis_lite_s.md
Name:
axis_lite_s

Overview:
AXI4-Lite slave (responder) with NUM_REGS 32-bit read/write registers; the counterpart of axis_lite_m on the same axil_itf bus, so it replaces the Xilinx VIP slave in TB_AXI_Lite and serves as the control-register block in designs. Independent write and read paths, byte-strobe writes, SLVERR for out-of-range addresses, all register contents exported flat to user logic.

Parameters:
ADDR_W, 32, width of awaddr/araddr
NUM_REGS, 16, number of 32-bit registers (>=1); register i sits at BASE_ADDR + 4*i
BASE_ADDR, 32'h0000_0000, byte address of register 0 (4-byte aligned)

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awprot  in  3  accepted, ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables; bit k covers wdata[8k+7:8k]
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response: OKAY 2'b00, SLVERR 2'b10
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_W  read address
s_axi_arprot  in  3  accepted, ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response: OKAY/SLVERR
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
reg_out  out  NUM_REGS*32  register contents; reg i at [32i+31:32i]

Behaviour:
- Reset (aresetn=0, asynchronous): all registers 0; awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; in-flight transactions dropped. The first edge after release sets awready/wready/arready to 1.
- Decode: index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored. Out of range if addr < BASE_ADDR or index >= NUM_REGS.
- Write path, states W_IDLE / W_HAVE_AW / W_HAVE_W / W_RESP. AW and W are captured independently, each handshake clears its own ready. Either order, or the same cycle, is accepted.
- Write commit: on the edge that completes the second of AW/W, in-range bytes with wstrb=1 are written, and bvalid=1 with bresp OKAY. Out-of-range: no write, bresp SLVERR. wstrb=0 with an in-range address: no change, OKAY.
- Write response: bvalid and bresp are held stable until bready=1. On the B handshake edge, bvalid=0 and awready=wready=1. Best case is one write per 2 cycles.
- Read path, states R_IDLE / R_RESP. On the AR handshake edge, rdata is taken from the current register value (0 if out of range), rresp is set (OKAY, or SLVERR if out of range), rvalid=1 and arready=0. rdata, rresp and rvalid are held until rready=1. On the R handshake edge, rvalid=0 and arready=1. Latency is 1 cycle.
- Read/write to the same register on the same edge: the read returns the pre-write value.
- Read and write paths are fully concurrent; neither stalls the other.
- reg_out is registered and reflects a commit from the cycle after the commit edge.

Decomposition:
- Package axil_pkg: RESP_OKAY, RESP_SLVERR, AXIL_DATA_W=32, AXIL_STRB_W=4, and the write/read state enums.
- Sub-module axil_regbank: register storage, byte-strobe write, asynchronous read mux by index. The parent holds the handshake FSMs and the decode.

Test Plan:
1. Release reset; AW=BASE+0x8 and W=32'h5aa5_a55a, wstrb=4'hF, both in the same cycle -> bvalid the next cycle, bresp 00; reg_out[2]=32'h5aa5_a55a; a read of 0x8 returns the same value with rresp 00.
2. W is presented 3 cycles before AW (and then the reverse order) -> a single commit after the later handshake; bvalid asserted exactly once.
3. Reg 1 = 32'h1122_3344, then write 32'hAABB_CCDD with wstrb=4'b0101 -> reg 1 = 32'h11BB_33DD.
4. Write and read 32'haaaa_bbbb (out of range) -> bresp 10 with no register changed; rresp 10 with rdata 0.
5. bready and rready held low for 5 cycles -> bvalid/bresp and rvalid/rdata stay stable, and awready/wready/arready stay 0 until the handshake.
6. aresetn pulsed low while bvalid=1 and rvalid=1 -> all outputs and registers are 0 immediately; after release, readies=1 and a new write completes normally.
